// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module : imm_gen_pipe
// Desc   : Registered immediate generator with class tag, illegal-opcode
//          counter and a two-entry skid buffer on the decode path.
// Rev    : 1.0
// ============================================================================
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           ir_i,
  input  logic                  ir_valid_i,
  output logic                  ir_ready_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [2:0]            kind_o,
  output logic                  illegal_o,
  output logic                  imm_valid_o,
  input  logic                  imm_ready_i,
  output logic [CNT_WIDTH-1:0]  illegal_cnt_o
);

  localparam logic [2:0] C_KIND_I     = 3'd0;
  localparam logic [2:0] C_KIND_S     = 3'd1;
  localparam logic [2:0] C_KIND_B     = 3'd2;
  localparam logic [2:0] C_KIND_U     = 3'd3;
  localparam logic [2:0] C_KIND_J     = 3'd4;
  localparam logic [2:0] C_KIND_SHAMT = 3'd5;
  localparam logic [2:0] C_KIND_ZIMM  = 3'd6;
  localparam logic [2:0] C_KIND_ILL   = 3'd7;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [DATA_WIDTH-1:0] w_imm_shamt, w_imm_zimm;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [2:0]            w_kind;
  logic                  w_illegal;
  logic                  w_accept, w_consume;

  logic                  r_out_valid, r_skid_valid;
  logic [DATA_WIDTH-1:0] r_out_imm, r_skid_imm;
  logic [2:0]            r_out_kind, r_skid_kind;
  logic                  r_out_ill, r_skid_ill;
  logic [CNT_WIDTH-1:0]  r_cnt;

  assign w_opcode = ir_i[6:0];
  assign w_funct3 = ir_i[14:12];

  assign w_imm_i    = {{(DATA_WIDTH-12){ir_i[31]}}, ir_i[31:20]};
  assign w_imm_s    = {{(DATA_WIDTH-12){ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  assign w_imm_b    = {{(DATA_WIDTH-12){ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign w_imm_u    = {{(DATA_WIDTH-31){ir_i[31]}}, ir_i[30:12], 12'b0};
  assign w_imm_j    = {{(DATA_WIDTH-20){ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
  assign w_imm_zimm = {{(DATA_WIDTH-5){1'b0}}, ir_i[19:15]};

  // RV64 shifts use a 6-bit shamt; funct7 never leaks into the immediate.
  generate
    if (DATA_WIDTH == 64) begin : g_shamt64
      assign w_imm_shamt = {{(DATA_WIDTH-6){1'b0}}, ir_i[25:20]};
    end else begin : g_shamt32
      assign w_imm_shamt = {{(DATA_WIDTH-5){1'b0}}, ir_i[24:20]};
    end
  endgenerate

  always_comb begin
    w_imm  = '0;
    w_kind = C_KIND_ILL;
    case (w_opcode)
      C_OP_LOAD, C_OP_JALR: begin
        w_imm  = w_imm_i;
        w_kind = C_KIND_I;
      end
      C_OP_IMM: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_imm  = w_imm_shamt;
          w_kind = C_KIND_SHAMT;
        end else begin
          w_imm  = w_imm_i;
          w_kind = C_KIND_I;
        end
      end
      C_OP_STORE: begin
        w_imm  = w_imm_s;
        w_kind = C_KIND_S;
      end
      C_OP_BRANCH: begin
        w_imm  = w_imm_b;
        w_kind = C_KIND_B;
      end
      C_OP_LUI, C_OP_AUIPC: begin
        w_imm  = w_imm_u;
        w_kind = C_KIND_U;
      end
      C_OP_JAL: begin
        w_imm  = w_imm_j;
        w_kind = C_KIND_J;
      end
      C_OP_SYSTEM: begin
        if (w_funct3 == 3'b101 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
          w_imm  = w_imm_zimm;
          w_kind = C_KIND_ZIMM;
        end else begin
          w_imm  = w_imm_i;
          w_kind = C_KIND_I;
        end
      end
      default: ;
    endcase
  end

  assign w_illegal = (w_kind == C_KIND_ILL);

  // Ready comes from registered state only, so no path from imm_ready_i.
  assign ir_ready_o = !r_skid_valid && !reset_i;
  assign w_accept   = ir_valid_i && ir_ready_o;
  assign w_consume  = r_out_valid && imm_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_kind   <= 3'd0;
      r_out_ill    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_kind  <= 3'd0;
      r_skid_ill   <= 1'b0;
    end else if (w_accept) begin
      // SKID is known empty here because ready is gated on it.
      if (!r_out_valid || w_consume) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_kind  <= w_kind;
        r_out_ill   <= w_illegal;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_imm   <= w_imm;
        r_skid_kind  <= w_kind;
        r_skid_ill   <= w_illegal;
      end
    end else if (w_consume) begin
      if (r_skid_valid) begin
        r_out_imm    <= r_skid_imm;
        r_out_kind   <= r_skid_kind;
        r_out_ill    <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign imm_valid_o   = r_out_valid;
  assign imm_o         = r_out_imm;
  assign kind_o        = r_out_kind;
  assign illegal_o     = r_out_ill;
  assign illegal_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_gen_pipe
// Desc   : Directed and randomized self-checking bench for imm_gen_pipe.
// Rev    : 1.0
// ============================================================================
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] ir;
  logic        ir_valid;
  logic        imm_ready;

  logic        rdy32, val32, ill32;
  logic [31:0] imm32;
  logic [2:0]  kind32;
  logic [15:0] cnt32;

  logic        rdy64, val64, ill64;
  logic [63:0] imm64;
  logic [2:0]  kind64;
  logic [15:0] cnt64;

  logic        rdyc, valc, illc;
  logic [31:0] immc;
  logic [2:0]  kindc;
  logic [1:0]  cntc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .ir_i(ir), .ir_valid_i(ir_valid), .ir_ready_o(rdy32),
    .imm_o(imm32), .kind_o(kind32), .illegal_o(ill32), .imm_valid_o(val32),
    .imm_ready_i(imm_ready), .illegal_cnt_o(cnt32));

  imm_gen_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut64 (
    .clk_i(clk), .reset_i(reset_i), .ir_i(ir), .ir_valid_i(ir_valid), .ir_ready_o(rdy64),
    .imm_o(imm64), .kind_o(kind64), .illegal_o(ill64), .imm_valid_o(val64),
    .imm_ready_i(imm_ready), .illegal_cnt_o(cnt64));

  imm_gen_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_c2 (
    .clk_i(clk), .reset_i(reset_i), .ir_i(ir), .ir_valid_i(ir_valid), .ir_ready_o(rdyc),
    .imm_o(immc), .kind_o(kindc), .illegal_o(illc), .imm_valid_o(valc),
    .imm_ready_i(imm_ready), .illegal_cnt_o(cntc));

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [2:0]  k;
  } exp_t;

  // Reference decode straight from the encoding tables, using signed arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t              e;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    longint            v;
    logic [2:0]        f3;
    f3 = w[14:12];
    v = 0;
    e.k = 3'd7;
    case (w[6:0])
      7'h03, 7'h67: begin s12 = w[31:20]; v = s12; e.k = 3'd0; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) e.k = 3'd5;
        else begin s12 = w[31:20]; v = s12; e.k = 3'd0; end
      end
      7'h23: begin s12 = {w[31:25], w[11:7]}; v = s12; e.k = 3'd1; end
      7'h63: begin s13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = s13; e.k = 3'd2; end
      7'h37, 7'h17: begin s32 = {w[31:12], 12'h000}; v = s32; e.k = 3'd3; end
      7'h6F: begin s21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = s21; e.k = 3'd4; end
      7'h73: begin
        if (f3 >= 3'd5) begin v = longint'(w[19:15]); e.k = 3'd6; end
        else begin s12 = w[31:20]; v = s12; e.k = 3'd0; end
      end
      default: ;
    endcase
    if (e.k == 3'd5) begin
      e.i64 = 64'(w[25:20]);
      e.i32 = 32'(w[24:20]);
    end else begin
      e.i64 = v;
      e.i32 = v[31:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; ir = '0; ir_valid = 1'b0; imm_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (rdy32 !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", rdy32); end
    n_vec++; if (val32 !== 1'b0 || val64 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b/%b exp 0", val32, val64); end
    n_vec++; if (imm32 !== 32'h0 || kind32 !== 3'd0 || ill32 !== 1'b0) begin n_err++; $display("FAIL reset_payload got %h/%0d/%b exp 0/0/0", imm32, kind32, ill32); end
    n_vec++; if (cnt32 !== 16'h0 || cntc !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0", cnt32, cntc); end
    reset_i = 1'b0;
    #1;
    n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL release_ready got %b exp 1", rdy32); end
  endtask

  task automatic test_stream();
    imm_ready = 1'b1; ir_valid = 1'b1;
    ir = 32'hFFF00093; tick();
    n_vec++; if (val32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || kind32 !== 3'd0) begin n_err++; $display("FAIL stream_addi got %b/%h/%0d exp 1/ffffffff/0", val32, imm32, kind32); end
    ir = 32'h4030D093; tick();
    n_vec++; if (imm32 !== 32'h3 || kind32 !== 3'd5 || imm64 !== 64'h3) begin n_err++; $display("FAIL stream_srai got %h/%0d/%h exp 3/5/3", imm32, kind32, imm64); end
    ir = 32'hFF9FF06F; tick();
    n_vec++; if (imm32 !== 32'hFFFFFFF8 || kind32 !== 3'd4 || imm64 !== 64'hFFFFFFFFFFFFFFF8) begin n_err++; $display("FAIL stream_jal got %h/%0d/%h exp fffffff8/4", imm32, kind32, imm64); end
    n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL stream_ready got %b exp 1", rdy32); end
    ir = 32'h3002D073; tick();
    n_vec++; if (imm32 !== 32'h5 || kind32 !== 3'd6 || imm64 !== 64'h5) begin n_err++; $display("FAIL zimm got %h/%0d/%h exp 5/6/5", imm32, kind32, imm64); end
    ir = 32'h03F09093; tick();
    n_vec++; if (imm64 !== 64'h3F || kind64 !== 3'd5) begin n_err++; $display("FAIL shamt64 got %h/%0d exp 3f/5", imm64, kind64); end
    n_vec++; if (imm32 !== 32'h1F || kind32 !== 3'd5) begin n_err++; $display("FAIL shamt32 got %h/%0d exp 1f/5", imm32, kind32); end
    ir_valid = 1'b0; tick();
    n_vec++; if (val32 !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b exp 0", val32); end
  endtask

  task automatic test_illegal();
    imm_ready = 1'b1; ir_valid = 1'b1;
    ir = 32'h00000000; tick();
    n_vec++; if (imm32 !== 32'h0 || kind32 !== 3'd7 || ill32 !== 1'b1) begin n_err++; $display("FAIL illegal_zero got %h/%0d/%b exp 0/7/1", imm32, kind32, ill32); end
    ir = 32'h0000007F; tick();
    n_vec++; if (imm64 !== 64'h0 || kind64 !== 3'd7 || ill64 !== 1'b1) begin n_err++; $display("FAIL illegal_7f got %h/%0d/%b exp 0/7/1", imm64, kind64, ill64); end
    n_vec++; if (cnt32 !== 16'd2 || cntc !== 2'd2) begin n_err++; $display("FAIL illegal_cnt2 got %0d/%0d exp 2/2", cnt32, cntc); end
    ir = 32'h0000000B;
    repeat (3) tick();
    ir_valid = 1'b0; tick();
    n_vec++; if (cnt32 !== 16'd5) begin n_err++; $display("FAIL illegal_cnt5 got %0d exp 5", cnt32); end
    n_vec++; if (cntc !== 2'd3) begin n_err++; $display("FAIL illegal_sat got %0d exp 3", cntc); end
  endtask

  task automatic test_back_to_back();
    imm_ready = 1'b0; ir_valid = 1'b1;
    ir = 32'h00100093; tick();
    n_vec++; if (val32 !== 1'b1 || imm32 !== 32'h1 || rdy32 !== 1'b1) begin n_err++; $display("FAIL bp_a got %b/%h/%b exp 1/1/1", val32, imm32, rdy32); end
    ir = 32'h12345037; tick();
    n_vec++; if (rdy32 !== 1'b0 || imm32 !== 32'h1) begin n_err++; $display("FAIL bp_skid got rdy %b imm %h exp 0/1", rdy32, imm32); end
    ir = 32'h00000463; tick();
    n_vec++; if (rdy32 !== 1'b0 || imm32 !== 32'h1 || kind32 !== 3'd0 || val32 !== 1'b1) begin n_err++; $display("FAIL bp_hold got rdy %b imm %h k %0d exp 0/1/0", rdy32, imm32, kind32); end
    imm_ready = 1'b1; tick();
    n_vec++; if (imm32 !== 32'h12345000 || kind32 !== 3'd3 || rdy32 !== 1'b1) begin n_err++; $display("FAIL bp_b got %h/%0d rdy %b exp 12345000/3/1", imm32, kind32, rdy32); end
    tick();
    n_vec++; if (val32 !== 1'b1 || imm32 !== 32'h8 || kind32 !== 3'd2) begin n_err++; $display("FAIL bp_c got %b/%h/%0d exp 1/8/2", val32, imm32, kind32); end
    ir_valid = 1'b0; tick();
    n_vec++; if (val32 !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b exp 0", val32); end
  endtask

  task automatic test_reset_mid();
    imm_ready = 1'b0; ir_valid = 1'b1;
    ir = 32'h00000000; tick();
    ir = 32'h00500093; tick();
    n_vec++; if (rdy32 !== 1'b0 || val32 !== 1'b1) begin n_err++; $display("FAIL rm_full got rdy %b val %b exp 0/1", rdy32, val32); end
    ir_valid = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    n_vec++; if (val32 !== 1'b0 || val64 !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b/%b exp 0", val32, val64); end
    n_vec++; if (cnt32 !== 16'd0 || cntc !== 2'd0) begin n_err++; $display("FAIL rm_cnt got %0d/%0d exp 0", cnt32, cntc); end
    @(negedge clk);
    #1;
    reset_i = 1'b0; ir_valid = 1'b1; ir = 32'h00700093; imm_ready = 1'b1;
    #1;
    n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL rm_ready got %b exp 1", rdy32); end
    tick();
    n_vec++; if (val32 !== 1'b1 || imm32 !== 32'h7) begin n_err++; $display("FAIL rm_first got %b/%h exp 1/7", val32, imm32); end
    ir_valid = 1'b0; tick();
    n_vec++; if (val32 !== 1'b0) begin n_err++; $display("FAIL rm_drain got %b exp 0", val32); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [6:0]  ops [0:9];
    logic [31:0] w;
    int          n_acc = 0;
    int          n_ill = 0;
    int          cyc = 0;
    int          pick;
    bit          do_acc, do_cons;
    ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h13};
    while ((n_acc < 10000 || q.size() > 0) && cyc < 60000) begin
      w = $urandom;
      pick = $urandom_range(0, 11);
      if (pick < 10) w[6:0] = ops[pick];
      ir = w;
      if (n_acc < 10000) begin
        ir_valid  = ($urandom_range(0, 3) != 0);
        imm_ready = ($urandom_range(0, 3) != 0);
      end else begin
        ir_valid  = 1'b0;
        imm_ready = 1'b1;
      end
      n_vec++; if (rdy32 !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, rdy32, q.size() < 2); end
      n_vec++; if (val32 !== (q.size() > 0) || val64 !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b/%b exp %b", cyc, val32, val64, q.size() > 0); end
      if (q.size() > 0) begin
        n_vec++;
        if (imm32 !== q[0].i32 || kind32 !== q[0].k || ill32 !== (q[0].k == 3'd7) ||
            imm64 !== q[0].i64 || kind64 !== q[0].k) begin
          n_err++;
          $display("FAIL rnd_data cyc %0d got %h/%h/%0d exp %h/%h/%0d", cyc, imm32, imm64, kind32, q[0].i32, q[0].i64, q[0].k);
        end
      end
      n_vec++;
      if (cnt32 !== 16'((n_ill > 65535) ? 65535 : n_ill) || cntc !== 2'((n_ill > 3) ? 3 : n_ill)) begin
        n_err++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d", cyc, cnt32, cntc, n_ill);
      end
      do_cons = (q.size() > 0) && imm_ready;
      do_acc  = ir_valid && (q.size() < 2);
      if (do_cons) void'(q.pop_front());
      if (do_acc) begin
        e = ref_decode(w);
        q.push_back(e);
        n_acc++;
        if (e.k == 3'd7) n_ill++;
      end
      tick();
      cyc++;
    end
    n_vec++; if (n_acc < 10000 || q.size() != 0) begin n_err++; $display("FAIL rnd_budget accepted %0d pending %0d exp 10000/0", n_acc, q.size()); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
